// File: rtl/batchnorm_denorm.sv
// rtl/batchnorm_denorm.sv - inverse batch-norm: x = ((y - beta) * sigma) / gamma + mean
// Handshaked multi-cycle datapath with a restoring divider sequenced by a single FSM.
module batchnorm_denorm #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] gamma,
  input  logic [WIDTH-1:0] beta,
  input  logic [WIDTH-1:0] mean,
  input  logic [WIDTH-1:0] sigma,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic             div_err,
  output logic             busy
);

  localparam int PW    = 2 * WIDTH + 1;
  localparam int CW    = $clog2(PW);
  // Product carries 2*FRAC fraction bits, gamma FRAC, so the quotient already matches mean.
  localparam int ALIGN = (2 * FRAC - FRAC) - FRAC;

  localparam logic signed [PW:0]   Q_MAX  = {1'b0, {PW{1'b1}}};
  localparam logic signed [PW+1:0] SAT_HI = {{(PW + 3 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW+1:0] SAT_LO = {{(PW + 3 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SUB, S_MUL, S_DIV, S_ADD, S_OUT} state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_y, r_g, r_b, r_m, r_s;
  logic [WIDTH:0]        r_diff;
  logic [PW-1:0]         r_dvd;
  logic [WIDTH:0]        r_dsr;
  logic [WIDTH:0]        r_rem;
  logic [PW-1:0]         r_quo;
  logic [CW-1:0]         r_cnt;
  logic signed [PW:0]    r_qs;
  logic                  r_neg, r_pneg, r_pzero, r_gzero;

  logic [PW-1:0]         w_prod;
  logic [PW-1:0]         w_pmag;
  logic [WIDTH:0]        w_gmag;
  logic [WIDTH+1:0]      w_trial;
  logic                  w_ge;
  logic [WIDTH:0]        w_rem_n;
  logic [PW-1:0]         w_quo_n;
  logic signed [PW:0]    w_q_al;
  logic signed [PW+1:0]  w_sum;
  logic [WIDTH-1:0]      w_sat;

  always_comb begin
    w_prod  = {{(PW - WIDTH - 1){r_diff[WIDTH]}}, r_diff} * {{(PW - WIDTH){r_s[WIDTH-1]}}, r_s};
    w_pmag  = w_prod[PW-1] ? (~w_prod + 1'b1) : w_prod;
    w_gmag  = r_g[WIDTH-1] ? (~{1'b1, r_g} + 1'b1) : {1'b0, r_g};
    w_trial = {r_rem, r_dvd[PW-1]};
    w_ge    = w_trial >= {1'b0, r_dsr};
    w_rem_n = w_ge ? (w_trial[WIDTH:0] - r_dsr) : w_trial[WIDTH:0];
    w_quo_n = {r_quo[PW-2:0], w_ge};
    w_q_al  = r_qs >>> ALIGN;
    w_sum   = {w_q_al[PW], w_q_al} + {{(PW + 2 - WIDTH){r_m[WIDTH-1]}}, r_m};
    if (w_sum > SAT_HI)      w_sat = {1'b0, {(WIDTH - 1){1'b1}}};
    else if (w_sum < SAT_LO) w_sat = {1'b1, {(WIDTH - 1){1'b0}}};
    else                     w_sat = w_sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_s       <= '0;
      r_diff    <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_qs      <= '0;
      r_neg     <= 1'b0;
      r_pneg    <= 1'b0;
      r_pzero   <= 1'b0;
      r_gzero   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_out     <= '0;
      div_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_y      <= y_in;
            r_g      <= gamma;
            r_b      <= beta;
            r_m      <= mean;
            r_s      <= sigma;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_SUB;
          end
        end
        S_SUB: begin
          r_diff  <= {r_y[WIDTH-1], r_y} - {r_b[WIDTH-1], r_b};
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_dvd   <= w_pmag;
          r_dsr   <= w_gmag;
          r_rem   <= '0;
          r_quo   <= '0;
          r_cnt   <= '0;
          r_neg   <= w_prod[PW-1] ^ r_g[WIDTH-1];
          r_pneg  <= w_prod[PW-1];
          r_pzero <= (w_prod == '0);
          r_gzero <= (r_g == '0);
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_dvd <= {r_dvd[PW-2:0], 1'b0};
          r_rem <= w_rem_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(PW - 1)) begin
            // A zero divisor runs the same iterations; its quotient is replaced here.
            if (r_gzero)
              r_qs <= r_pzero ? '0 : (r_pneg ? -Q_MAX : Q_MAX);
            else
              r_qs <= r_neg ? -$signed({1'b0, w_quo_n}) : $signed({1'b0, w_quo_n});
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          x_out     <= w_sat;
          div_err   <= r_gzero;
          out_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_batchnorm_denorm.sv
// tb/tb_batchnorm_denorm.sv - randomized and directed self-checking bench for batchnorm_denorm
// Reference model evaluates the arithmetic formula directly with 64-bit integers.
module tb_batchnorm_denorm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y_in = '0, gamma = '0, beta = '0, mean = '0, sigma = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] x_out;
  logic        div_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  batchnorm_denorm #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .gamma(gamma), .beta(beta), .mean(mean), .sigma(sigma),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .div_err(div_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] y, g, b, m, s, output logic err);
    longint diff, prod, q, sum;
    diff = longint'($signed(y)) - longint'($signed(b));
    prod = diff * longint'($signed(s));
    if (g == 16'h0000) begin
      err = 1'b1;
      q = (prod > 0) ? (longint'(1) <<< 40) : (prod < 0) ? -(longint'(1) <<< 40) : 0;
    end else begin
      err = 1'b0;
      q = prod / longint'($signed(g));
    end
    sum = q + longint'($signed(m));
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum[15:0];
  endfunction

  // Drives one sample, optionally pulses in_valid with junk while busy, and
  // consumes the result only when out_ready is high.
  task automatic run_sample(input logic [15:0] y, g, b, m, s, input bit noise,
                            output int lat, output logic [15:0] x, output logic e);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    y_in = y; gamma = g; beta = b; mean = m; sigma = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    y_in = 16'($urandom); gamma = 16'($urandom); beta = 16'($urandom);
    mean = 16'($urandom); sigma = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    x = x_out;
    e = div_err;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== 16'h0 || div_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b x_out=%h div_err=%b busy=%b, required 1 0 0000 0 0",
               in_ready, out_valid, x_out, div_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] vec [8][5];
    logic [15:0] req [8];
    logic        req_err [8];
    int          lat;
    logic [15:0] x;
    logic        e;
    vec[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h0500, 16'h0200}; req[0] = 16'h0700; req_err[0] = 0;
    vec[1] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0500, 16'h0200}; req[1] = 16'h0300; req_err[1] = 0;
    vec[2] = '{16'h0280, 16'h0200, 16'h0080, 16'h0000, 16'h0100}; req[2] = 16'h0100; req_err[2] = 0;
    vec[3] = '{16'h7F00, 16'h0100, 16'h0000, 16'h0000, 16'h0400}; req[3] = 16'h7FFF; req_err[3] = 0;
    vec[4] = '{16'h8100, 16'h0100, 16'h0000, 16'h0000, 16'h0400}; req[4] = 16'h8000; req_err[4] = 0;
    vec[5] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100}; req[5] = 16'h7FFF; req_err[5] = 1;
    vec[6] = '{16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100}; req[6] = 16'h0100; req_err[6] = 0;
    vec[7] = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0100}; req[7] = 16'h8000; req_err[7] = 1;
    for (int i = 0; i < 8; i++) begin
      run_sample(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], 1'b0, lat, x, e);
      checks++;
      if (lat !== 36 || x !== req[i] || e !== req_err[i]) begin
        errors++;
        $display("FAIL directed[%0d]: lat=%0d x_out=%h div_err=%b, required lat=36 x_out=%h div_err=%b",
                 i, lat, x, e, req[i], req_err[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] y, g, b, m, s, x, req;
    logic        e, req_e;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      y = 16'($urandom); b = 16'($urandom); m = 16'($urandom); s = 16'($urandom);
      case ($urandom_range(0, 3))
        0: g = 16'h0000;
        1: g = 16'($urandom_range(0, 255)) | 16'h0001;
        default: g = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        y = 16'($signed(y) >>> 4); b = 16'($signed(b) >>> 4); s = 16'($signed(s) >>> 6);
      end
      req = model(y, g, b, m, s, req_e);
      run_sample(y, g, b, m, s, 1'b1, lat, x, e);
      checks++;
      if (lat !== 36 || x !== req || e !== req_e || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] y=%h g=%h b=%h m=%h s=%h: lat=%0d x_out=%h err=%b ov=%b ir=%b, required 36 %h %b 0 1",
                 i, y, g, b, m, s, lat, x, e, out_valid, in_ready, req, req_e);
      end
    end
  endtask

  task automatic test_handshake;
    logic [15:0] x, req;
    logic        e, req_e;
    int          lat;
    req = model(16'h0180, 16'h0100, 16'h0000, 16'h0100, 16'h0200, req_e);
    out_ready = 1'b0;
    run_sample(16'h0180, 16'h0100, 16'h0000, 16'h0100, 16'h0200, 1'b1, lat, x, e);
    checks++;
    if (lat !== 36 || x !== req || e !== req_e) begin
      errors++;
      $display("FAIL stall_result: lat=%0d x_out=%h err=%b, required 36 %h %b", lat, x, e, req, req_e);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      y_in = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (x_out !== req || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: x_out=%h ov=%b ir=%b busy=%b, required %h 1 0 1",
                 i, x_out, out_valid, in_ready, busy, req);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: ov=%b ir=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] yy;
      yy = 16'($urandom_range(0, 16'h0800));
      req = model(yy, 16'h0080, 16'h0040, 16'hFE00, 16'h0180, req_e);
      run_sample(yy, 16'h0080, 16'h0040, 16'hFE00, 16'h0180, 1'b0, lat, x, e);
      checks++;
      if (lat !== 36 || x !== req || e !== req_e || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back[%0d]: lat=%0d x_out=%h err=%b ov=%b, required 36 %h %b 0",
                 i, lat, x, e, out_valid, req, req_e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] x, req;
    logic        e, req_e;
    int          lat;
    run_sample(16'h0100, 16'h0100, 16'h0000, 16'h0500, 16'h0200, 1'b0, lat, x, e);
    y_in = 16'h0200; gamma = 16'h0100; beta = 16'h0000; mean = 16'h0000; sigma = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || x_out !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b1 || div_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b x_out=%h busy=%b ir=%b err=%b, required 0 0000 0 1 0",
               out_valid, x_out, busy, in_ready, div_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req = model(16'hFE80, 16'hFF00, 16'h0000, 16'h0100, 16'h0100, req_e);
    run_sample(16'hFE80, 16'hFF00, 16'h0000, 16'h0100, 16'h0100, 1'b0, lat, x, e);
    checks++;
    if (lat !== 36 || x !== req || e !== req_e) begin
      errors++;
      $display("FAIL after_reset: lat=%0d x_out=%h err=%b, required 36 %h %b", lat, x, e, req, req_e);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_handshake;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
